// File: rtl/reorder_buffer.sv
// In-order retirement buffer: multi-lane allocate, out-of-order completion,
// in-order retire with flush on the first flagged (exception/mispredict) entry.
module reorder_buffer #(
    parameter int NUM_ENTS = 64,
    parameter int DISP_W   = 2,
    parameter int RET_W    = 4,
    parameter int CMPL_W   = 4,
    parameter int AREG_W   = 5,
    parameter int PREG_W   = 7,
    parameter int PC_W     = 32,
    localparam int IDX_W   = $clog2(NUM_ENTS),
    localparam int PTR_W   = IDX_W + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DISP_W-1:0]              disp_valid,
    input  logic [DISP_W-1:0][AREG_W-1:0]  disp_dst_areg,
    input  logic [DISP_W-1:0][PREG_W-1:0]  disp_dst_preg,
    input  logic [DISP_W-1:0][PC_W-1:0]    disp_pc,
    input  logic [DISP_W-1:0]              disp_has_dst,
    output logic                           disp_ready,
    output logic [DISP_W-1:0][IDX_W-1:0]   disp_idx,
    input  logic [CMPL_W-1:0]              cmpl_valid,
    input  logic [CMPL_W-1:0][IDX_W-1:0]   cmpl_idx,
    input  logic [CMPL_W-1:0]              cmpl_exception,
    input  logic [CMPL_W-1:0]              cmpl_br_mispred,
    output logic [RET_W-1:0]               ret_valid,
    output logic [RET_W-1:0][AREG_W-1:0]   ret_dst_areg,
    output logic [RET_W-1:0][PREG_W-1:0]   ret_dst_preg,
    output logic [RET_W-1:0]               ret_has_dst,
    output logic [RET_W-1:0][PC_W-1:0]     ret_pc,
    output logic                           flush,
    output logic [PC_W-1:0]                flush_pc,
    output logic [PTR_W-1:0]               count,
    output logic                           empty,
    output logic                           full
);

    logic [PTR_W-1:0]  head_r, tail_r, count_s, k_disp_s, k_ret_s, head_nxt_s, tail_nxt_s;
    logic [NUM_ENTS-1:0] done_r, flag_r, set_done_s, set_flag_s, clr_s;
    logic [AREG_W-1:0] areg_r [NUM_ENTS];
    logic [PREG_W-1:0] preg_r [NUM_ENTS];
    logic [PC_W-1:0]   pc_r   [NUM_ENTS];
    logic              has_dst_r [NUM_ENTS];
    logic [IDX_W-1:0]  ret_idx_s [RET_W];
    logic [IDX_W-1:0]  cmpl_off_s [CMPL_W];
    logic [CMPL_W-1:0] cmpl_hit_s;
    logic              disp_en_s;
    logic              blocked_s;

    assign count_s    = tail_r - head_r;
    assign count      = count_s;
    assign empty      = (count_s == PTR_W'(0));
    assign full       = (head_r[IDX_W-1:0] == tail_r[IDX_W-1:0]) && (head_r[IDX_W] != tail_r[IDX_W]);
    // Readiness looks only at registered occupancy; same-cycle retires give no credit.
    assign disp_ready = (count_s <= PTR_W'(NUM_ENTS - DISP_W));
    assign disp_en_s  = disp_ready & ~flush;

    for (genvar g = 0; g < RET_W; g++) begin : g_ret_idx
        assign ret_idx_s[g] = head_r[IDX_W-1:0] + IDX_W'(g);
    end

    // An index is live when its distance from head is below the occupancy.
    for (genvar g = 0; g < CMPL_W; g++) begin : g_cmpl_hit
        assign cmpl_off_s[g] = cmpl_idx[g] - head_r[IDX_W-1:0];
        assign cmpl_hit_s[g] = cmpl_valid[g] & ({1'b0, cmpl_off_s[g]} < count_s) & ~flush;
    end

    // Dispatch lane count, lane indices and done/flag clear mask.
    always_comb begin
        k_disp_s = PTR_W'(0);
        clr_s    = {NUM_ENTS{1'b0}};
        for (int l = 0; l < DISP_W; l++) begin
            disp_idx[l] = tail_r[IDX_W-1:0] + IDX_W'(l);
            if (disp_valid[l]) begin
                k_disp_s = k_disp_s + PTR_W'(1);
                clr_s[disp_idx[l]] = disp_en_s;
            end else begin
                k_disp_s = k_disp_s;
            end
        end
    end

    // Completion set masks; several ports on one index merge their flags.
    always_comb begin
        set_done_s = {NUM_ENTS{1'b0}};
        set_flag_s = {NUM_ENTS{1'b0}};
        for (int p = 0; p < CMPL_W; p++) begin
            if (cmpl_hit_s[p]) begin
                set_done_s[cmpl_idx[p]] = 1'b1;
                set_flag_s[cmpl_idx[p]] = set_flag_s[cmpl_idx[p]] | cmpl_exception[p] | cmpl_br_mispred[p];
            end else begin
                set_done_s = set_done_s;
            end
        end
    end

    // Retire selection: contiguous done entries from head, cut after the first flagged one.
    always_comb begin
        ret_valid = {RET_W{1'b0}};
        k_ret_s   = PTR_W'(0);
        flush     = 1'b0;
        flush_pc  = {PC_W{1'b0}};
        blocked_s = 1'b0;
        for (int i = 0; i < RET_W; i++) begin
            ret_dst_areg[i] = areg_r[ret_idx_s[i]];
            ret_dst_preg[i] = preg_r[ret_idx_s[i]];
            ret_has_dst[i]  = has_dst_r[ret_idx_s[i]];
            ret_pc[i]       = pc_r[ret_idx_s[i]];
            if (!blocked_s && (PTR_W'(i) < count_s) && done_r[ret_idx_s[i]]) begin
                ret_valid[i] = 1'b1;
                k_ret_s      = k_ret_s + PTR_W'(1);
                if (flag_r[ret_idx_s[i]]) begin
                    flush     = 1'b1;
                    flush_pc  = pc_r[ret_idx_s[i]];
                    blocked_s = 1'b1;
                end else begin
                    blocked_s = 1'b0;
                end
            end else begin
                blocked_s = 1'b1;
            end
        end
    end

    // Next head/tail; a flush empties the buffer and drops same-cycle dispatch.
    always_comb begin
        head_nxt_s = head_r + k_ret_s;
        if (flush) begin
            tail_nxt_s = head_nxt_s;
        end else if (disp_ready) begin
            tail_nxt_s = tail_r + k_disp_s;
        end else begin
            tail_nxt_s = tail_r;
        end
    end

    // Pointers and per-entry status bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r <= PTR_W'(0);
            tail_r <= PTR_W'(0);
            done_r <= {NUM_ENTS{1'b0}};
            flag_r <= {NUM_ENTS{1'b0}};
        end else begin
            head_r <= head_nxt_s;
            tail_r <= tail_nxt_s;
            done_r <= (done_r & ~clr_s) | set_done_s;
            flag_r <= (flag_r & ~clr_s) | set_flag_s;
        end
    end

    // Payload storage, written on accepted dispatch only.
    always_ff @(posedge clk) begin
        for (int l = 0; l < DISP_W; l++) begin
            if (disp_en_s && disp_valid[l]) begin
                areg_r[disp_idx[l]]    <= disp_dst_areg[l];
                preg_r[disp_idx[l]]    <= disp_dst_preg[l];
                pc_r[disp_idx[l]]      <= disp_pc[l];
                has_dst_r[disp_idx[l]] <= disp_has_dst[l];
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed plus randomized bench for reorder_buffer, checked every cycle against
// a queue-based model of the in-order buffer.
module tb_reorder_buffer;

    localparam int N = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      disp_valid = 2'b00;
    logic [1:0][4:0] disp_dst_areg = '0;
    logic [1:0][6:0] disp_dst_preg = '0;
    logic [1:0][31:0] disp_pc = '0;
    logic [1:0]      disp_has_dst = 2'b00;
    logic            disp_ready;
    logic [1:0][5:0] disp_idx;
    logic [3:0]      cmpl_valid = 4'b0000;
    logic [3:0][5:0] cmpl_idx = '0;
    logic [3:0]      cmpl_exception = 4'b0000;
    logic [3:0]      cmpl_br_mispred = 4'b0000;
    logic [3:0]      ret_valid;
    logic [3:0][4:0] ret_dst_areg;
    logic [3:0][6:0] ret_dst_preg;
    logic [3:0]      ret_has_dst;
    logic [3:0][31:0] ret_pc;
    logic            flush;
    logic [31:0]     flush_pc;
    logic [6:0]      count;
    logic            empty, full;

    reorder_buffer dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_dst_areg(disp_dst_areg), .disp_dst_preg(disp_dst_preg),
        .disp_pc(disp_pc), .disp_has_dst(disp_has_dst), .disp_ready(disp_ready), .disp_idx(disp_idx),
        .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx), .cmpl_exception(cmpl_exception),
        .cmpl_br_mispred(cmpl_br_mispred),
        .ret_valid(ret_valid), .ret_dst_areg(ret_dst_areg), .ret_dst_preg(ret_dst_preg),
        .ret_has_dst(ret_has_dst), .ret_pc(ret_pc), .flush(flush), .flush_pc(flush_pc),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  areg;
        logic [6:0]  preg;
        logic        hd;
        bit          done;
        bit          flag;
    } ent_t;

    ent_t q[$];
    int   mh = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_empty"}, 64'(empty), 64'd1);
        chk({tag, "_full"}, 64'(full), 64'd0);
        chk({tag, "_ready"}, 64'(disp_ready), 64'd1);
        chk({tag, "_ret_valid"}, 64'(ret_valid), 64'd0);
        chk({tag, "_flush"}, 64'(flush), 64'd0);
        chk({tag, "_flush_pc"}, 64'(flush_pc), 64'd0);
    endtask

    // One clock: compare outputs with the model, advance the model, clear inputs.
    task automatic cycle();
        logic [3:0]  erv;
        logic [31:0] efpc;
        bit          ef;
        bit          ready_pre;
        int          kr;
        ent_t        e;
        @(negedge clk);
        erv = 4'b0000; efpc = 32'd0; ef = 1'b0; kr = 0;
        for (int k = 0; k < 4; k++) begin
            if (k >= q.size()) break;
            if (!q[k].done) break;
            erv[k] = 1'b1;
            kr++;
            if (q[k].flag) begin
                ef = 1'b1;
                efpc = q[k].pc;
                break;
            end
        end
        ready_pre = (q.size() <= N - 2);
        chk("count", 64'(count), 64'(q.size()));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("full", 64'(full), 64'(q.size() == N));
        chk("disp_ready", 64'(disp_ready), 64'(ready_pre));
        chk("disp_idx0", 64'(disp_idx[0]), 64'((mh + q.size()) % N));
        chk("disp_idx1", 64'(disp_idx[1]), 64'((mh + q.size() + 1) % N));
        chk("ret_valid", 64'(ret_valid), 64'(erv));
        chk("flush", 64'(flush), 64'(ef));
        chk("flush_pc", 64'(flush_pc), 64'(efpc));
        for (int k = 0; k < kr; k++) begin
            chk("ret_pc", 64'(ret_pc[k]), 64'(q[k].pc));
            chk("ret_payload", 64'({ret_dst_areg[k], ret_dst_preg[k], ret_has_dst[k]}),
                64'({q[k].areg, q[k].preg, q[k].hd}));
        end
        if (ef) begin
            mh = (mh + kr) % N;
            q.delete();
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (cmpl_valid[p]) begin
                    int off;
                    off = (int'(cmpl_idx[p]) - mh + N) % N;
                    if (off < q.size()) begin
                        q[off].done = 1'b1;
                        q[off].flag = q[off].flag | cmpl_exception[p] | cmpl_br_mispred[p];
                    end
                end
            end
            repeat (kr) void'(q.pop_front());
            mh = (mh + kr) % N;
            if (ready_pre) begin
                for (int l = 0; l < 2; l++) begin
                    if (disp_valid[l]) begin
                        e.pc = disp_pc[l]; e.areg = disp_dst_areg[l]; e.preg = disp_dst_preg[l];
                        e.hd = disp_has_dst[l]; e.done = 1'b0; e.flag = 1'b0;
                        q.push_back(e);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        disp_valid = 2'b00;
        cmpl_valid = 4'b0000;
        cmpl_exception = 4'b0000;
        cmpl_br_mispred = 4'b0000;
    endtask

    task automatic set_lane(input int l, input logic [31:0] pc);
        disp_valid[l] = 1'b1;
        disp_pc[l] = pc;
        disp_dst_areg[l] = 5'($urandom);
        disp_dst_preg[l] = 7'($urandom);
        disp_has_dst[l] = 1'($urandom);
    endtask

    task automatic set_cmpl(input int p, input int idx, input bit exc, input bit mis);
        cmpl_valid[p] = 1'b1;
        cmpl_idx[p] = 6'(idx);
        cmpl_exception[p] = exc;
        cmpl_br_mispred[p] = mis;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two-lane dispatch, then out-of-order completion
        set_lane(0, 32'h100);
        set_lane(1, 32'h104);
        chk("first_idx0", 64'(disp_idx[0]), 64'd0);
        chk("first_idx1", 64'(disp_idx[1]), 64'd1);
        cycle();
        chk("count_two", 64'(count), 64'd2);
        set_cmpl(0, 1, 1'b0, 1'b0);
        cycle();
        chk("no_retire_idx1", 64'(ret_valid), 64'd0);
        set_cmpl(1, 0, 1'b0, 1'b0);
        cycle();
        chk("pair_retire", 64'(ret_valid), 64'h3);
        cycle();

        // Fill to capacity; extra dispatch ignored
        for (int i = 0; i < 32; i++) begin
            set_lane(0, 32'h1000 + 32'(8 * i));
            set_lane(1, 32'h1004 + 32'(8 * i));
            cycle();
        end
        chk("full_at_64", 64'(full), 64'd1);
        chk("ready_at_64", 64'(disp_ready), 64'd0);
        set_lane(0, 32'hdead);
        set_lane(1, 32'hbeef);
        cycle();
        for (int p = 0; p < 4; p++) set_cmpl(p, (mh + p) % N, 1'b0, 1'b0);
        cycle();
        chk("retire4", 64'(ret_valid), 64'hf);
        cycle();
        chk("ready_after_retire", 64'(disp_ready), 64'd1);
        chk("count_60", 64'(count), 64'd60);

        // Exception at head flushes everything
        set_cmpl(0, mh, 1'b1, 1'b0);
        cycle();
        chk("exc_flush", 64'(flush), 64'd1);
        cycle();
        chk("empty_after_exc", 64'(empty), 64'd1);

        // Mispredict on third of four entries; same-cycle dispatch dropped
        set_lane(0, 32'h200); set_lane(1, 32'h204); cycle();
        set_lane(0, 32'h208); set_lane(1, 32'h20c); cycle();
        for (int p = 0; p < 4; p++) set_cmpl(p, (mh + p) % N, 1'b0, p == 2);
        cycle();
        set_lane(0, 32'h300); set_lane(1, 32'h304);
        chk("mis_ret_valid", 64'(ret_valid), 64'h7);
        chk("mis_flush", 64'(flush), 64'd1);
        chk("mis_flush_pc", 64'(flush_pc), 64'h208);
        cycle();
        chk("mis_count0", 64'(count), 64'd0);

        // Randomized traffic across many wraps
        for (int c = 0; c < 600; c++) begin
            int k;
            k = $urandom_range(0, 2);
            for (int l = 0; l < k; l++) set_lane(l, 32'($urandom) & 32'hfffffffc);
            for (int p = 0; p < 4; p++) begin
                if ($urandom_range(0, 3) != 0) begin
                    int idx;
                    if (q.size() > 0 && $urandom_range(0, 9) < 8)
                        idx = (mh + $urandom_range(0, q.size() - 1)) % N;
                    else
                        idx = $urandom_range(0, N - 1);
                    set_cmpl(p, idx, $urandom_range(0, 79) == 0, $urandom_range(0, 79) == 0);
                end
            end
            cycle();
        end

        // Asynchronous reset with live entries
        while (q.size() < 10) begin
            set_lane(0, 32'h400); set_lane(1, 32'h404);
            cycle();
        end
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        #3;
        rst = 1'b0;
        q.delete();
        mh = 0;
        @(posedge clk);
        #1;
        set_lane(0, 32'h500);
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
